// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef logic [0:0] master_idx_t;

    localparam master_idx_t M0 = 1'b0;
    localparam master_idx_t M1 = 1'b1;

    localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

    function automatic master_idx_t other_master(input master_idx_t m);
        return ~m;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: on a tie the master that was not served last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic        v0,
    input  logic        v1,
    input  master_idx_t last,
    output logic        any,
    output master_idx_t pick
);

    // Combinational pick among the requesting masters
    always_comb begin
        any  = v0 | v1;
        pick = M0;
        if (v0 && v1) begin
            pick = other_master(last);
        end else if (v1) begin
            pick = M1;
        end else begin
            pick = M0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory bus between two masters.
// Optional slave-silence watchdog is enabled by defining MEM_ARB_WATCHDOG_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    arb_state_e  state_r;
    arb_state_e  state_nxt_s;
    master_idx_t grant_r;
    master_idx_t last_r;
    logic        any_s;
    master_idx_t pick_s;
    logic        done_s;
    logic        timeout_s;
    logic        end_s;
    logic [31:0] rdata_s;

    mem_arb_rr u_rr (
        .v0   (m0_valid),
        .v1   (m1_valid),
        .last (last_r),
        .any  (any_s),
        .pick (pick_s)
    );

    assign s_valid = (state_r == BUSY);
    assign done_s  = s_valid & s_ready;
    assign end_s   = done_s | timeout_s;
    // A real slave answer always beats the watchdog in the same cycle.
    assign rdata_s = done_s ? s_rdata : ERR_RDATA;

    // Slave-side request mux, forced to zero outside a transaction
    always_comb begin
        s_addr  = 32'h0000_0000;
        s_wdata = 32'h0000_0000;
        s_wstrb = 4'b0000;
        if (state_r == BUSY) begin
            case (grant_r)
                M0: begin
                    s_addr  = m0_addr;
                    s_wdata = m0_wdata;
                    s_wstrb = m0_wstrb;
                end
                M1: begin
                    s_addr  = m1_addr;
                    s_wdata = m1_wdata;
                    s_wstrb = m1_wstrb;
                end
                default: begin
                    s_addr  = 32'h0000_0000;
                    s_wdata = 32'h0000_0000;
                    s_wstrb = 4'b0000;
                end
            endcase
        end else begin
            s_addr  = 32'h0000_0000;
            s_wdata = 32'h0000_0000;
            s_wstrb = 4'b0000;
        end
    end

    // Completion pulse and read data routed to the granted master only
    always_comb begin
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = 32'h0000_0000;
        m1_rdata = 32'h0000_0000;
        if (end_s) begin
            if (grant_r == M0) begin
                m0_ready = 1'b1;
                m0_rdata = rdata_s;
            end else begin
                m1_ready = 1'b1;
                m1_rdata = rdata_s;
            end
        end else begin
            m0_ready = 1'b0;
            m1_ready = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (end_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, grant and fairness history registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            grant_r <= M0;
            last_r  <= M1;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && any_s) begin
                grant_r <= pick_s;
            end
            if (end_s) begin
                last_r <= grant_r;
            end
        end
    end

`ifdef MEM_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt_r;
    logic        bus_err_r;
    logic [31:0] err_addr_r;

    assign timeout_s = s_valid & ~s_ready & (wd_cnt_r == WD_LAST);
    assign bus_err   = bus_err_r;
    assign err_addr  = err_addr_r;

    // Watchdog counter, held at zero while idle so it starts fresh in BUSY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_r <= 16'd0;
        end else if (state_r == IDLE) begin
            wd_cnt_r <= 16'd0;
        end else if (!s_ready) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end
    end

    // Sticky error flag; address of the first timeout only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err_r  <= 1'b0;
            err_addr_r <= 32'h0000_0000;
        end else if (timeout_s) begin
            bus_err_r <= 1'b1;
            if (!bus_err_r) begin
                err_addr_r <= s_addr;
            end
        end
    end
`else
    logic unused_cfg_s;

    assign timeout_s    = 1'b0;
    assign bus_err      = 1'b0;
    assign err_addr     = 32'h0000_0000;
    assign unused_cfg_s = ^WD_LAST;
`endif

endmodule
